// File: rtl/reg_write_buffer_if.sv
// Bundle of the write-buffer request, register-file and query signals.
// The slave modport is the buffer itself; master is whoever drives it.
interface reg_write_buffer_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [N-1:0]  in_mask;
  logic [N-1:0]  in_data;
  logic          rf_hold;
  logic [AW-1:0] rf_w1;
  logic [N-1:0]  rf_mask;
  logic [N-1:0]  rf_w;
  logic [AW-1:0] q_addr;
  logic [AW-1:0] rf_r1;
  logic [N-1:0]  rf_v1;
  logic [N-1:0]  q_value;
  logic          q_pending;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_addr, in_mask, in_data, rf_hold, q_addr, rf_v1,
    output in_ready, rf_w1, rf_mask, rf_w, rf_r1, q_value, q_pending, count
  );

  modport master (
    output in_valid, in_addr, in_mask, in_data, rf_hold, q_addr, rf_v1,
    input  in_ready, rf_w1, rf_mask, rf_w, rf_r1, q_value, q_pending, count
  );
endinterface

// File: rtl/reg_write_buffer.sv
// Masked writeback FIFO in front of a register file; drains one entry per cycle and
// answers queries with all still-pending writes merged over the register-file value.
module reg_write_buffer #(
  parameter int unsigned N     = 32,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  reg_write_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [N-1:0]  mask_q [DEPTH];
  logic [N-1:0]  data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic          in_ready;
  logic [PW-1:0] idx;
  logic [N-1:0]  merged;
  logic          pending;

  // Full means no accept, even when the head drains this same cycle.
  assign in_ready = (count_q < CW'(DEPTH)) && !rst;
  assign push     = bus.in_valid && in_ready;
  assign pop      = (count_q != '0) && !bus.rf_hold && !rst;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.in_addr;
      mask_q[tail_q] <= bus.in_mask;
      data_q[tail_q] <= bus.in_data;
    end
  end

  // Oldest-to-newest merge; the head stays included while it is being written.
  always_comb begin
    merged  = bus.rf_v1;
    pending = 1'b0;
    idx     = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == bus.q_addr)) begin
        merged = (merged & ~mask_q[idx]) | (data_q[idx] & mask_q[idx]);
        if (mask_q[idx] != '0) pending = 1'b1;
      end
    end
    if (rst) begin
      merged  = bus.rf_v1;
      pending = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rf_w1     = addr_q[head_q];
  assign bus.rf_w      = data_q[head_q];
  assign bus.rf_mask   = pop ? mask_q[head_q] : '0;
  assign bus.rf_r1     = bus.q_addr;
  assign bus.q_value   = merged;
  assign bus.q_pending = pending;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_reg_write_buffer.sv
// Directed bench for reg_write_buffer with a small masked register-file model behind it.
module tb_reg_write_buffer;
  localparam int unsigned N     = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [N-1:0] regs [4];

  reg_write_buffer_if #(.N(N), .AW(AW), .DEPTH(DEPTH)) bus ();

  reg_write_buffer #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) regs[i] = '0;

  always @(posedge clk) begin
    regs[bus.rf_w1] <= (regs[bus.rf_w1] & ~bus.rf_mask) | (bus.rf_w & bus.rf_mask);
  end

  assign bus.rf_v1 = regs[bus.rf_r1];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [N-1:0] m,
                       input logic [N-1:0] d);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_mask  = m;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    bus.rf_hold = 1'b0;
    bus.q_addr  = '0;
    step();
    step();
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    n_checks++;
    if (bus.rf_mask !== 32'h0) begin
      n_fail++; $display("FAIL reset_rf_mask: got %h want 0", bus.rf_mask);
    end
    n_checks++;
    if (bus.count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.rf_mask !== 32'h0) begin
      n_fail++; $display("FAIL release_rf_mask: got %h want 0", bus.rf_mask);
    end
  endtask

  task automatic test_single_write();
    step();
    drive(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hBABE_C0FF);
    bus.q_addr = 2'd0;
    step();
    drive(1'b0, '0, '0, '0);
    #1;
    n_checks++;
    if (bus.rf_w1 !== 2'd0 || bus.rf_mask !== 32'hFFFF_FFFF || bus.rf_w !== 32'hBABE_C0FF) begin
      n_fail++;
      $display("FAIL single_drain: got w1=%0d mask=%h w=%h want 0/ffffffff/babec0ff",
               bus.rf_w1, bus.rf_mask, bus.rf_w);
    end
    n_checks++;
    if (bus.count !== 3'd1) begin
      n_fail++; $display("FAIL single_count: got %0d want 1", bus.count);
    end
    n_checks++;
    if (bus.q_value !== 32'hBABE_C0FF || bus.q_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL single_query: got %h/%b want babec0ff/1", bus.q_value, bus.q_pending);
    end
    step();
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.rf_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL single_empty: got count=%0d mask=%h want 0/0", bus.count, bus.rf_mask);
    end
    n_checks++;
    if (regs[0] !== 32'hBABE_C0FF || bus.q_value !== 32'hBABE_C0FF || bus.q_pending !== 1'b0)
    begin
      n_fail++;
      $display("FAIL single_reg0: got reg=%h q=%h pend=%b want babec0ff/babec0ff/0",
               regs[0], bus.q_value, bus.q_pending);
    end
  endtask

  task automatic test_masked_merge();
    bus.rf_hold = 1'b1;
    drive(1'b1, 2'd2, 32'hF0F0_F0F0, 32'hCFBF_BFEF);
    step();
    drive(1'b1, 2'd2, 32'h0F0F_0F0F, 32'hF0FE_FEFF);
    step();
    drive(1'b0, '0, '0, '0);
    bus.q_addr = 2'd2;
    #1;
    n_checks++;
    if (bus.q_value !== 32'hC0BE_BEEF || bus.q_pending !== 1'b1 || bus.rf_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL merge_held: got q=%h pend=%b mask=%h want c0bebeef/1/0",
               bus.q_value, bus.q_pending, bus.rf_mask);
    end
    step();
    bus.rf_hold = 1'b0;
    #1;
    n_checks++;
    if (bus.rf_w1 !== 2'd2 || bus.rf_mask !== 32'hF0F0_F0F0 || bus.q_value !== 32'hC0BE_BEEF)
    begin
      n_fail++;
      $display("FAIL merge_drain1: got w1=%0d mask=%h q=%h want 2/f0f0f0f0/c0bebeef",
               bus.rf_w1, bus.rf_mask, bus.q_value);
    end
    step();
    #1;
    n_checks++;
    if (bus.rf_mask !== 32'h0F0F_0F0F || bus.q_value !== 32'hC0BE_BEEF || bus.count !== 3'd1)
    begin
      n_fail++;
      $display("FAIL merge_drain2: got mask=%h q=%h count=%0d want 0f0f0f0f/c0bebeef/1",
               bus.rf_mask, bus.q_value, bus.count);
    end
    step();
    #1;
    n_checks++;
    if (bus.q_value !== 32'hC0BE_BEEF || bus.q_pending !== 1'b0 || regs[2] !== 32'hC0BE_BEEF)
    begin
      n_fail++;
      $display("FAIL merge_done: got q=%h pend=%b reg2=%h want c0bebeef/0/c0bebeef",
               bus.q_value, bus.q_pending, regs[2]);
    end
  endtask

  task automatic test_full_backpressure();
    bus.rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i), 32'hFFFF_FFFF, 32'h0000_1000 + i);
      step();
    end
    drive(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_DEAD);
    #1;
    n_checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state: got count=%0d ready=%b want 4/0", bus.count, bus.in_ready);
    end
    step();
    drive(1'b0, '0, '0, '0);
    bus.rf_hold = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_accept: got count=%0d ready=%b want 4/0", bus.count, bus.in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (bus.rf_w1 !== AW'(k) || bus.rf_w !== 32'h0000_1000 + k ||
          bus.rf_mask !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL full_drain%0d: got w1=%0d w=%h mask=%h want %0d/%h/ffffffff",
                 k, bus.rf_w1, bus.rf_w, bus.rf_mask, k, 32'h0000_1000 + k);
      end
      step();
      #1;
      if (k == 0) begin
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.count !== 3'd3) begin
          n_fail++;
          $display("FAIL full_ready_return: got ready=%b count=%0d want 1/3",
                   bus.in_ready, bus.count);
        end
      end
    end
    n_checks++;
    if (bus.count !== 3'd0 || bus.rf_mask !== 32'h0 || regs[1] !== 32'h0000_1001) begin
      n_fail++;
      $display("FAIL full_empty: got count=%0d mask=%h reg1=%h want 0/0/00001001",
               bus.count, bus.rf_mask, regs[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step();
      drive(i < 5, AW'(i % 4), 32'hFFFF_FFFF, 32'hA000_0000 + i);
      #1;
      if (i >= 1) begin
        n_checks++;
        if (bus.count !== 3'd1 || bus.rf_w1 !== AW'((i - 1) % 4) ||
            bus.rf_w !== 32'hA000_0000 + (i - 1) || bus.rf_mask !== 32'hFFFF_FFFF) begin
          n_fail++;
          $display("FAIL b2b_%0d: got count=%0d w1=%0d w=%h mask=%h want 1/%0d/%h/ffffffff",
                   i, bus.count, bus.rf_w1, bus.rf_w, bus.rf_mask, (i - 1) % 4,
                   32'hA000_0000 + (i - 1));
        end
      end
    end
    step();
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || regs[0] !== 32'hA000_0004 || regs[3] !== 32'hA000_0003) begin
      n_fail++;
      $display("FAIL b2b_end: got count=%0d reg0=%h reg3=%h want 0/a0000004/a0000003",
               bus.count, regs[0], regs[3]);
    end
  endtask

  task automatic test_reset_mid();
    bus.rf_hold = 1'b1;
    bus.q_addr  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h5555_0000 + i);
    end
    step();
    drive(1'b0, '0, '0, '0);
    #1;
    n_checks++;
    if (bus.count !== 3'd3 || bus.q_pending !== 1'b1 || bus.q_value !== 32'h5555_0002) begin
      n_fail++;
      $display("FAIL mid_pending: got count=%0d pend=%b q=%h want 3/1/55550002",
               bus.count, bus.q_pending, bus.q_value);
    end
    step();
    rst = 1'b1;
    bus.rf_hold = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.rf_mask !== 32'h0 || bus.q_pending !== 1'b0 ||
        bus.q_value !== 32'hA000_0001) begin
      n_fail++;
      $display("FAIL mid_in_reset: got ready=%b mask=%h pend=%b q=%h want 0/0/0/a0000001",
               bus.in_ready, bus.rf_mask, bus.q_pending, bus.q_value);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== 3'd0 || bus.rf_mask !== 32'h0 || bus.q_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: got count=%0d mask=%h pend=%b want 0/0/0",
               bus.count, bus.rf_mask, bus.q_pending);
    end
    step();
    step();
    #1;
    n_checks++;
    if (regs[1] !== 32'hA000_0001 || bus.rf_mask !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_discard: got reg1=%h mask=%h want a0000001/0", regs[1], bus.rf_mask);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_masked_merge();
    test_full_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
